hw_accel_frame_ctrl: RTL and testbench



---
 rtl/hw_accel_frame_ctrl.sv | 194 +++++++++++++++++++
 tb/tb_hw_accel_frame_ctrl.sv | 335 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/hw_accel_frame_ctrl.sv
// Frame sequencer for the Sobel/dilation/erosion accelerator: gates one frame of DMA pixels, counts results, reports status/irq.
// Optional performance counter on frame_cycles is built only when HW_ACCEL_PERF_CNT_EN is defined.
module hw_accel_frame_ctrl #(
  parameter int DATA_WIDTH     = 8,
  parameter int IMG_WIDTH      = 512,
  parameter int IMG_HEIGHT     = 512,
  parameter int TIMEOUT_CYCLES = 65535
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic                  abort,
  input  logic                  irq_clr,
  input  logic [1:0]            cfg_mode,
  input  logic [DATA_WIDTH-1:0] cfg_thresh,
  input  logic [DATA_WIDTH-1:0] s_data,
  input  logic                  s_valid,
  output logic                  s_ready,
  output logic [1:0]            acc_mode,
  output logic [DATA_WIDTH-1:0] acc_thresh,
  output logic [DATA_WIDTH-1:0] acc_pixel_in,
  output logic                  acc_pixel_in_valid,
  input  logic [DATA_WIDTH-1:0] acc_pixel_out,
  input  logic                  acc_pixel_out_valid,
  output logic [DATA_WIDTH-1:0] m_data,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic                  busy,
  output logic                  done,
  output logic                  irq,
  output logic [2:0]            status,
  output logic [31:0]           frame_cycles
);

  localparam int FRAME_PIXELS = IMG_WIDTH * IMG_HEIGHT;
  localparam int CW           = $clog2(FRAME_PIXELS + 1);
  localparam logic [CW-1:0] FRAME_LAST = CW'(FRAME_PIXELS);
  localparam logic [15:0]   TMO_LIMIT  = 16'(TIMEOUT_CYCLES);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    RUN   = 2'd2,
    FLUSH = 2'd3
  } state_t;

  state_t                state_q;
  logic                  s_ready_q;
  logic                  busy_q;
  logic                  done_q;
  logic                  irq_q;
  logic [2:0]            status_q;
  logic [1:0]            acc_mode_q;
  logic [DATA_WIDTH-1:0] acc_thresh_q;
  logic [DATA_WIDTH-1:0] acc_pixel_in_q;
  logic                  acc_pixel_in_valid_q;
  logic [DATA_WIDTH-1:0] m_data_q;
  logic                  m_valid_q;
  logic [CW-1:0]         in_cnt_q;
  logic [CW-1:0]         out_cnt_q;
  logic [15:0]           tmo_cnt_q;

  logic                  xfer;
  logic [CW-1:0]         in_cnt_inc;
  logic [CW-1:0]         out_cnt_d;
  logic                  frame_done;
  logic                  frame_timeout;
  logic                  overrun;
  logic [2:0]            status_d;
  logic                  irq_d;

  // Completion looks at out_cnt_d so a result arriving on the final FLUSH
  // cycle still beats the timeout; abort suppresses both events.
  always_comb begin
    xfer       = (state_q == RUN) && s_ready_q && s_valid;
    in_cnt_inc = in_cnt_q + CW'(1);
    out_cnt_d  = out_cnt_q;
    if (busy_q && acc_pixel_out_valid && (out_cnt_q != FRAME_LAST)) begin
      out_cnt_d = out_cnt_q + CW'(1);
    end
    frame_done    = (state_q == FLUSH) && !abort && (out_cnt_d == FRAME_LAST);
    frame_timeout = (state_q == FLUSH) && !abort && !frame_done &&
                    ((tmo_cnt_q + 16'd1) == TMO_LIMIT);
    overrun       = m_valid_q && !m_ready;
    status_d      = irq_clr ? 3'b000 : status_q;
    status_d      = status_d | {overrun, frame_timeout, frame_done};
    irq_d         = (irq_clr ? 1'b0 : irq_q) | frame_done | frame_timeout;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q              <= IDLE;
      s_ready_q            <= 1'b0;
      busy_q               <= 1'b0;
      done_q               <= 1'b0;
      irq_q                <= 1'b0;
      status_q             <= '0;
      acc_mode_q           <= '0;
      acc_thresh_q         <= '0;
      acc_pixel_in_q       <= '0;
      acc_pixel_in_valid_q <= 1'b0;
      m_data_q             <= '0;
      m_valid_q            <= 1'b0;
      in_cnt_q             <= '0;
      out_cnt_q            <= '0;
      tmo_cnt_q            <= '0;
    end else begin
      m_data_q             <= acc_pixel_out;
      m_valid_q            <= acc_pixel_out_valid;
      out_cnt_q            <= out_cnt_d;
      status_q             <= status_d;
      irq_q                <= irq_d;
      done_q               <= frame_done;
      acc_pixel_in_valid_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start && !abort) begin
            state_q <= LOAD;
            busy_q  <= 1'b1;
          end
        end
        LOAD: begin
          if (abort) begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
          end else begin
            acc_mode_q   <= cfg_mode;
            acc_thresh_q <= cfg_thresh;
            in_cnt_q     <= '0;
            out_cnt_q    <= '0;
            tmo_cnt_q    <= '0;
            s_ready_q    <= 1'b1;
            state_q      <= RUN;
          end
        end
        RUN: begin
          if (abort) begin
            state_q   <= IDLE;
            busy_q    <= 1'b0;
            s_ready_q <= 1'b0;
          end else if (xfer) begin
            acc_pixel_in_q       <= s_data;
            acc_pixel_in_valid_q <= 1'b1;
            in_cnt_q             <= in_cnt_inc;
            if (in_cnt_inc == FRAME_LAST) begin
              s_ready_q <= 1'b0;
              state_q   <= FLUSH;
            end
          end
        end
        FLUSH: begin
          if (abort || frame_done || frame_timeout) begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
          end else begin
            tmo_cnt_q <= tmo_cnt_q + 16'd1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

`ifdef HW_ACCEL_PERF_CNT_EN
  logic [31:0] frame_cycles_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      frame_cycles_q <= '0;
    end else if (state_q == LOAD) begin
      frame_cycles_q <= '0;
    end else if (((state_q == RUN) || (state_q == FLUSH)) && (frame_cycles_q != '1)) begin
      frame_cycles_q <= frame_cycles_q + 32'd1;
    end
  end

  assign frame_cycles = frame_cycles_q;
`else
  assign frame_cycles = '0;
`endif

  assign s_ready            = s_ready_q;
  assign busy               = busy_q;
  assign done               = done_q;
  assign irq                = irq_q;
  assign status             = status_q;
  assign acc_mode           = acc_mode_q;
  assign acc_thresh         = acc_thresh_q;
  assign acc_pixel_in       = acc_pixel_in_q;
  assign acc_pixel_in_valid = acc_pixel_in_valid_q;
  assign m_data             = m_data_q;
  assign m_valid            = m_valid_q;

endmodule

// File: tb/tb_hw_accel_frame_ctrl.sv
// Directed bench for hw_accel_frame_ctrl on a 4x4 frame with a one-cycle-latency accelerator stand-in.
module tb_hw_accel_frame_ctrl;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic       abort = 1'b0;
  logic       irq_clr = 1'b0;
  logic [1:0] cfg_mode = 2'd0;
  logic [7:0] cfg_thresh = 8'd0;
  logic [7:0] s_data = 8'd0;
  logic       s_valid = 1'b0;
  logic       s_ready;
  logic [1:0] acc_mode;
  logic [7:0] acc_thresh;
  logic [7:0] acc_pixel_in;
  logic       acc_pixel_in_valid;
  logic [7:0] acc_out;
  logic       acc_out_v;
  logic [7:0] m_data;
  logic       m_valid;
  logic       m_ready = 1'b1;
  logic       busy;
  logic       done;
  logic       irq;
  logic [2:0] status;
  logic [31:0] frame_cycles;

  int vectors = 0;
  int miscompares = 0;

  logic model_clr = 1'b0;
  int   ret_limit = 16;
  int   ret_cnt;
  int   done_cnt, mv_cnt, ain_cnt, msum;
  int   d0, m0, a0, s0;
  int   xfer_cnt;
  int   k, ft, meas;

  hw_accel_frame_ctrl #(
    .DATA_WIDTH    (8),
    .IMG_WIDTH     (4),
    .IMG_HEIGHT    (4),
    .TIMEOUT_CYCLES(20)
  ) dut (
    .clk                (clk),
    .rst_n              (rst_n),
    .start              (start),
    .abort              (abort),
    .irq_clr            (irq_clr),
    .cfg_mode           (cfg_mode),
    .cfg_thresh         (cfg_thresh),
    .s_data             (s_data),
    .s_valid            (s_valid),
    .s_ready            (s_ready),
    .acc_mode           (acc_mode),
    .acc_thresh         (acc_thresh),
    .acc_pixel_in       (acc_pixel_in),
    .acc_pixel_in_valid (acc_pixel_in_valid),
    .acc_pixel_out      (acc_out),
    .acc_pixel_out_valid(acc_out_v),
    .m_data             (m_data),
    .m_valid            (m_valid),
    .m_ready            (m_ready),
    .busy               (busy),
    .done               (done),
    .irq                (irq),
    .status             (status),
    .frame_cycles       (frame_cycles)
  );

  always #5 clk = ~clk;

  // Accelerator stand-in: one cycle latency, result = pixel ^ 0xA5, returns at most ret_limit results.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_out   <= 8'd0;
      acc_out_v <= 1'b0;
      ret_cnt   <= 0;
    end else begin
      acc_out <= acc_pixel_in ^ 8'hA5;
      if (model_clr) begin
        ret_cnt   <= 0;
        acc_out_v <= 1'b0;
      end else if (acc_pixel_in_valid && ret_cnt < ret_limit) begin
        acc_out_v <= 1'b1;
        ret_cnt   <= ret_cnt + 1;
      end else begin
        acc_out_v <= 1'b0;
      end
    end
  end

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      done_cnt <= 0;
      mv_cnt   <= 0;
      ain_cnt  <= 0;
      msum     <= 0;
    end else begin
      if (done) done_cnt <= done_cnt + 1;
      if (m_valid) begin
        mv_cnt <= mv_cnt + 1;
        msum   <= msum + int'(m_data);
      end
      if (acc_pixel_in_valid) ain_cnt <= ain_cnt + 1;
    end
  end

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic int exp_sum(input int n);
    int s;
    logic [7:0] b;
    s = 0;
    for (int i = 1; i <= n; i++) begin
      b = 8'(i);
      s += int'(b ^ 8'hA5);
    end
    return s;
  endfunction

  task automatic snap();
    d0 = done_cnt;
    m0 = mv_cnt;
    a0 = ain_cnt;
    s0 = msum;
  endtask

  task automatic start_frame(input logic [1:0] mode, input logic [7:0] th, input int limit);
    ret_limit  = limit;
    model_clr  = 1'b1;
    cfg_mode   = mode;
    cfg_thresh = th;
    xfer_cnt   = 0;
    start      = 1'b1;
    tick();
    start     = 1'b0;
    model_clr = 1'b0;
    tick();
  endtask

  task automatic feed(input int n, input bit toggle, input bit stall_one, output int ticks);
    bit ph;
    bit stalled;
    ph      = 1'b1;
    stalled = 1'b0;
    ticks   = 0;
    while (xfer_cnt < n && ticks < 100) begin
      s_valid = toggle ? ph : 1'b1;
      ph      = !ph;
      s_data  = 8'(xfer_cnt + 1);
      m_ready = 1'b1;
      if (stall_one && !stalled && m_valid) begin
        m_ready = 1'b0;
        stalled = 1'b1;
      end
      if (s_valid && s_ready) xfer_cnt++;
      tick();
      ticks++;
    end
    s_valid = 1'b0;
    m_ready = 1'b1;
  endtask

  task automatic wait_end(output int cyc);
    cyc = 0;
    while (!(done || irq) && cyc < 100) begin
      tick();
      cyc++;
    end
  endtask

  task automatic clear_irq();
    irq_clr = 1'b1;
    tick();
    irq_clr = 1'b0;
  endtask

  initial begin
    tick();
    tick();
    chk("rst_s_ready", 32'(s_ready), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_irq", 32'(irq), 0);
    chk("rst_status", 32'(status), 0);
    chk("rst_done", 32'(done), 0);
    chk("rst_m_valid", 32'(m_valid), 0);
    chk("rst_acc_mode", 32'(acc_mode), 0);
    chk("rst_acc_thresh", 32'(acc_thresh), 0);
    chk("rst_ain_valid", 32'(acc_pixel_in_valid), 0);
    chk("rst_frame_cycles", frame_cycles, 0);
    rst_n = 1'b1;
    tick();

    // Frame 1: continuous input; cfg_mode changes mid-frame.
    snap();
    start_frame(2'd1, 8'd40, 16);
    chk("f1_busy", 32'(busy), 1);
    chk("f1_s_ready_hi", 32'(s_ready), 1);
    chk("f1_acc_mode", 32'(acc_mode), 1);
    chk("f1_acc_thresh", 32'(acc_thresh), 40);
    feed(5, 1'b0, 1'b0, ft);
    cfg_mode = 2'd2;
    feed(16, 1'b0, 1'b0, ft);
    chk("f1_xfers", 32'(xfer_cnt), 16);
    chk("f1_s_ready_lo", 32'(s_ready), 0);
    chk("f1_acc_mode_mid", 32'(acc_mode), 1);
    wait_end(k);
    chk("f1_done_pulse", 32'(done), 1);
    chk("f1_flush_cycles", 32'(k), 2);
    tick();
    chk("f1_done_one_cycle", 32'(done), 0);
    tick();
    chk("f1_done_cnt", 32'(done_cnt - d0), 1);
    chk("f1_status", 32'(status), 32'h1);
    chk("f1_irq", 32'(irq), 1);
    chk("f1_busy_end", 32'(busy), 0);
    chk("f1_acc_mode_end", 32'(acc_mode), 1);
    chk("f1_ain_cnt", 32'(ain_cnt - a0), 16);
    chk("f1_m_cnt", 32'(mv_cnt - m0), 16);
    chk("f1_m_sum", 32'(msum - s0), 32'(exp_sum(16)));
    clear_irq();
    chk("clr_irq", 32'(irq), 0);
    chk("clr_status", 32'(status), 0);

    // Frame 2: one result missing -> timeout after 20 FLUSH cycles.
    snap();
    start_frame(2'd2, 8'd40, 15);
    chk("f2_acc_mode", 32'(acc_mode), 2);
    feed(16, 1'b0, 1'b0, ft);
    chk("f2_xfers", 32'(xfer_cnt), 16);
    wait_end(k);
    chk("f2_timeout_latency", 32'(k), 20);
    chk("f2_status", 32'(status), 32'h2);
    chk("f2_irq", 32'(irq), 1);
    tick();
    tick();
    chk("f2_no_done", 32'(done_cnt - d0), 0);
    chk("f2_m_cnt", 32'(mv_cnt - m0), 15);
    clear_irq();

    // Frame 3: one output stalled -> overrun, frame still completes.
    snap();
    start_frame(2'd2, 8'd40, 16);
    feed(16, 1'b0, 1'b1, ft);
    wait_end(k);
    tick();
    tick();
    chk("f3_done_cnt", 32'(done_cnt - d0), 1);
    chk("f3_status", 32'(status), 32'h5);
    chk("f3_irq", 32'(irq), 1);
    clear_irq();

    // Frame 4: abort after 7 pixels, with s_valid still high on the abort cycle.
    snap();
    start_frame(2'd1, 8'd40, 16);
    feed(7, 1'b0, 1'b0, ft);
    abort   = 1'b1;
    s_valid = 1'b1;
    s_data  = 8'd8;
    tick();
    abort   = 1'b0;
    s_valid = 1'b0;
    chk("f4_busy", 32'(busy), 0);
    chk("f4_s_ready", 32'(s_ready), 0);
    chk("f4_ain_valid", 32'(acc_pixel_in_valid), 0);
    chk("f4_irq", 32'(irq), 0);
    repeat (6) tick();
    chk("f4_irq_later", 32'(irq), 0);
    chk("f4_status", 32'(status), 0);
    chk("f4_no_done", 32'(done_cnt - d0), 0);
    chk("f4_ain_cnt", 32'(ain_cnt - a0), 7);

    // start and abort together while idle: abort wins.
    start = 1'b1;
    abort = 1'b1;
    tick();
    start = 1'b0;
    abort = 1'b0;
    chk("sa_busy", 32'(busy), 0);
    tick();
    chk("sa_busy2", 32'(busy), 0);
    chk("sa_s_ready", 32'(s_ready), 0);

    // Frame 5: 50% s_valid duty, full frame after the abort; cycle count check.
    snap();
    start_frame(2'd1, 8'd40, 16);
    feed(16, 1'b1, 1'b0, ft);
    chk("f5_xfers", 32'(xfer_cnt), 16);
    wait_end(k);
    meas = ft + k;
    chk("f5_done_pulse", 32'(done), 1);
    chk("f5_meas_cycles", 32'(meas), 33);
    tick();
    tick();
    chk("f5_done_cnt", 32'(done_cnt - d0), 1);
    chk("f5_status", 32'(status), 32'h1);
    chk("f5_m_sum", 32'(msum - s0), 32'(exp_sum(16)));
`ifdef HW_ACCEL_PERF_CNT_EN
    chk("f5_frame_cycles", frame_cycles, 32'(meas));
`else
    chk("f5_frame_cycles", frame_cycles, 0);
`endif
    clear_irq();

    // Asynchronous reset mid-frame.
    start_frame(2'd3, 8'h77, 16);
    feed(3, 1'b0, 1'b0, ft);
    chk("rf_acc_mode", 32'(acc_mode), 3);
    #2 rst_n = 1'b0;
    #1;
    chk("rf_busy", 32'(busy), 0);
    chk("rf_s_ready", 32'(s_ready), 0);
    chk("rf_acc_mode_rst", 32'(acc_mode), 0);
    chk("rf_acc_thresh_rst", 32'(acc_thresh), 0);
    tick();
    rst_n = 1'b1;
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
